// File: rtl/fmt_packer_mc.sv
// fmt_packer_mc: multi-channel packet formatter. Tagged input words land in
// per-channel FIFOs; full-length or timed-out channels are framed into packets
// and handed to the consumer after a request/grant handshake, round-robin.
module fmt_packer_mc #(
    parameter int DW    = 32,
    parameter int NCH   = 4,
    parameter int CHW   = $clog2(NCH),
    parameter int DEPTH = 32,
    parameter int LW    = $clog2(DEPTH) + 1,
    parameter int TOW   = 16
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               a2f_val_i,
    input  logic [CHW-1:0]     a2f_id_i,
    input  logic [DW-1:0]      a2f_dat_i,
    output logic               f2a_ack_o,
    input  logic [3*NCH-1:0]   slv_len_i,
    input  logic [TOW-1:0]     timeout_i,
    output logic               fmt_req_o,
    output logic [CHW-1:0]     fmt_chid_o,
    output logic [LW-1:0]      fmt_length_o,
    input  logic               fmt_grant_i,
    output logic [DW-1:0]      fmt_data_o,
    output logic               fmt_start_o,
    output logic               fmt_end_o
);

    localparam int          AW   = $clog2(DEPTH);
    localparam int unsigned NCHU = NCH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SEND
    } state_e;

    state_e            state_q, state_d;
    logic [CHW-1:0]    chid_q, chid_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     sent_q, sent_d;
    logic [CHW-1:0]    ptr_q, ptr_d;

    logic [LW-1:0]     cnt_q  [NCH];
    logic [LW-1:0]     cnt_d  [NCH];
    logic [AW-1:0]     wptr_q [NCH];
    logic [AW-1:0]     wptr_d [NCH];
    logic [AW-1:0]     rptr_q [NCH];
    logic [AW-1:0]     rptr_d [NCH];
    logic [TOW-1:0]    tmr_q  [NCH];
    logic [TOW-1:0]    tmr_d  [NCH];
    logic [DW-1:0]     mem_q  [NCH][DEPTH];

    logic [LW-1:0]     need_len [NCH];
    logic [LW-1:0]     elig_len [NCH];
    logic [NCH-1:0]    elig;
    logic              wr_en;
    logic [NCH-1:0]    wr_ch;
    logic [NCH-1:0]    rd_ch;
    logic              pick_vld;
    logic [CHW-1:0]    pick_ch;

    // Code k selects 2^k words, clamped to the FIFO depth.
    function automatic logic [LW-1:0] dec_len(input logic [2:0] code);
        if (int'(code) >= AW) begin
            return LW'(DEPTH);
        end
        return LW'(1) << code;
    endfunction

    // Input acceptance: the addressed FIFO must have room and reset be released.
    always_comb begin
        f2a_ack_o = 1'b0;
        if (rstn_i && (int'(a2f_id_i) < NCH)) begin
            f2a_ack_o = (cnt_q[a2f_id_i] != LW'(DEPTH));
        end
    end

    // Per-channel write strobes.
    always_comb begin
        wr_en = a2f_val_i && f2a_ack_o;
        wr_ch = '0;
        for (int unsigned n = 0; n < NCHU; n++) begin
            wr_ch[n] = wr_en && (a2f_id_i == CHW'(n));
        end
    end

    // Eligibility: full packet at count >= L, short packet on idle timeout.
    always_comb begin
        elig = '0;
        for (int unsigned n = 0; n < NCHU; n++) begin
            need_len[n] = dec_len(slv_len_i[3*n +: 3]);
            elig_len[n] = need_len[n];
            if (cnt_q[n] >= need_len[n]) begin
                elig[n] = 1'b1;
            end else if ((timeout_i != '0) && (cnt_q[n] != '0) && (tmr_q[n] >= timeout_i)) begin
                elig[n]     = 1'b1;
                elig_len[n] = cnt_q[n];
            end
        end
    end

    // Round-robin pick: first eligible channel starting at ptr_q.
    always_comb begin
        int unsigned sum;
        pick_vld = 1'b0;
        pick_ch  = '0;
        for (int unsigned i = 0; i < NCHU; i++) begin
            sum = 32'(ptr_q) + i;
            if (sum >= NCHU) begin
                sum = sum - NCHU;
            end
            if (!pick_vld && elig[CHW'(sum)]) begin
                pick_vld = 1'b1;
                pick_ch  = CHW'(sum);
            end
        end
    end

    // Packet FSM: next state, latched packet header and packet outputs.
    always_comb begin
        state_d     = state_q;
        chid_d      = chid_q;
        len_d       = len_q;
        sent_d      = sent_q;
        ptr_d       = ptr_q;
        rd_ch       = '0;
        fmt_req_o   = 1'b0;
        fmt_start_o = 1'b0;
        fmt_end_o   = 1'b0;
        fmt_data_o  = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_REQ;
                    chid_d  = pick_ch;
                    len_d   = elig_len[pick_ch];
                    sent_d  = '0;
                    ptr_d   = (pick_ch == CHW'(NCH - 1)) ? '0 : pick_ch + CHW'(1);
                end
            end
            ST_REQ: begin
                fmt_req_o = 1'b1;
                if (fmt_grant_i) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                rd_ch[chid_q] = 1'b1;
                fmt_data_o    = mem_q[chid_q][rptr_q[chid_q]];
                fmt_start_o   = (sent_q == '0);
                fmt_end_o     = (sent_q == len_q - LW'(1));
                sent_d        = sent_q + LW'(1);
                if (fmt_end_o) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign fmt_chid_o   = chid_q;
    assign fmt_length_o = len_q;

    // FIFO pointers, occupancy and idle timers.
    always_comb begin
        for (int unsigned n = 0; n < NCHU; n++) begin
            cnt_d[n]  = cnt_q[n];
            wptr_d[n] = wptr_q[n];
            rptr_d[n] = rptr_q[n];
            tmr_d[n]  = tmr_q[n];
            if (wr_ch[n]) begin
                wptr_d[n] = wptr_q[n] + AW'(1);
            end
            if (rd_ch[n]) begin
                rptr_d[n] = rptr_q[n] + AW'(1);
            end
            if (wr_ch[n] && !rd_ch[n]) begin
                cnt_d[n] = cnt_q[n] + LW'(1);
            end else if (!wr_ch[n] && rd_ch[n]) begin
                cnt_d[n] = cnt_q[n] - LW'(1);
            end
            if (wr_ch[n] || (cnt_q[n] == '0) ||
                ((state_q == ST_IDLE) && pick_vld && (pick_ch == CHW'(n)))) begin
                tmr_d[n] = '0;
            end else if ((cnt_q[n] < need_len[n]) && (tmr_q[n] != '1)) begin
                tmr_d[n] = tmr_q[n] + TOW'(1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            chid_q  <= '0;
            len_q   <= '0;
            sent_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '{default: '0};
            wptr_q  <= '{default: '0};
            rptr_q  <= '{default: '0};
            tmr_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            chid_q  <= chid_d;
            len_q   <= len_d;
            sent_q  <= sent_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            tmr_q   <= tmr_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[a2f_id_i][wptr_q[a2f_id_i]] <= a2f_dat_i;
        end
    end

endmodule

// File: tb/tb_fmt_packer_mc.sv
// Self-checking bench for fmt_packer_mc: per-channel scoreboard queues are
// filled on accepted writes and drained as packet words appear.
module tb_fmt_packer_mc;

    localparam int DW    = 32;
    localparam int NCH   = 4;
    localparam int CHW   = 2;
    localparam int DEPTH = 32;
    localparam int LW    = 6;
    localparam int TOW   = 16;

    logic               clk_i = 1'b0;
    logic               rstn_i = 1'b0;
    logic               a2f_val_i = 1'b0;
    logic [CHW-1:0]     a2f_id_i = '0;
    logic [DW-1:0]      a2f_dat_i = '0;
    logic               f2a_ack_o;
    logic [3*NCH-1:0]   slv_len_i = '0;
    logic [TOW-1:0]     timeout_i = '0;
    logic               fmt_req_o;
    logic [CHW-1:0]     fmt_chid_o;
    logic [LW-1:0]      fmt_length_o;
    logic               fmt_grant_i = 1'b0;
    logic [DW-1:0]      fmt_data_o;
    logic               fmt_start_o;
    logic               fmt_end_o;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq [NCH][$];

    fmt_packer_mc #(
        .DW(DW), .NCH(NCH), .CHW(CHW), .DEPTH(DEPTH), .LW(LW), .TOW(TOW)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .a2f_val_i(a2f_val_i), .a2f_id_i(a2f_id_i), .a2f_dat_i(a2f_dat_i),
        .f2a_ack_o(f2a_ack_o), .slv_len_i(slv_len_i), .timeout_i(timeout_i),
        .fmt_req_o(fmt_req_o), .fmt_chid_o(fmt_chid_o), .fmt_length_o(fmt_length_o),
        .fmt_grant_i(fmt_grant_i), .fmt_data_o(fmt_data_o),
        .fmt_start_o(fmt_start_o), .fmt_end_o(fmt_end_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic set_code(input int ch, input logic [2:0] code);
        slv_len_i[3*ch +: 3] = code;
    endtask

    task automatic wr(input int ch, input logic [DW-1:0] d, input logic exp_ack);
        a2f_val_i = 1'b1;
        a2f_id_i  = CHW'(ch);
        a2f_dat_i = d;
        #1;
        checks++;
        if (f2a_ack_o !== exp_ack) begin
            errors++;
            $display("FAIL ack ch%0d: got %b required %b", ch, f2a_ack_o, exp_ack);
        end
        if (f2a_ack_o === 1'b1) mq[ch].push_back(d);
        @(posedge clk_i);
        #1;
        a2f_val_i = 1'b0;
    endtask

    task automatic wait_req(output int lat);
        lat = 0;
        while (fmt_req_o !== 1'b1 && lat < 300) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        checks++;
        if (fmt_req_o !== 1'b1) begin
            errors++;
            $display("FAIL req_timeout: req=%b required 1", fmt_req_o);
        end
    endtask

    task automatic recv(input int ch, input int len, input int gdly);
        int lat;
        logic [DW-1:0] exp;
        wait_req(lat);
        if (fmt_req_o !== 1'b1) return;
        checks++;
        if (fmt_chid_o !== CHW'(ch)) begin
            errors++;
            $display("FAIL chid: got %0d required %0d", fmt_chid_o, ch);
        end
        checks++;
        if (fmt_length_o !== LW'(len)) begin
            errors++;
            $display("FAIL length ch%0d: got %0d required %0d", ch, fmt_length_o, len);
        end
        repeat (gdly) begin
            cyc(1);
            checks++;
            if (fmt_req_o !== 1'b1) begin
                errors++;
                $display("FAIL req_hold: got %b required 1", fmt_req_o);
            end
        end
        fmt_grant_i = 1'b1;
        @(posedge clk_i);
        #1;
        fmt_grant_i = 1'b0;
        checks++;
        if (fmt_req_o !== 1'b0) begin
            errors++;
            $display("FAIL req_fall: got %b required 0", fmt_req_o);
        end
        for (int i = 0; i < len; i++) begin
            exp = (mq[ch].size() > 0) ? mq[ch].pop_front() : 'x;
            checks++;
            if (fmt_data_o !== exp) begin
                errors++;
                $display("FAIL data ch%0d word%0d: got %h required %h", ch, i, fmt_data_o, exp);
            end
            checks++;
            if (fmt_start_o !== (i == 0) || fmt_end_o !== (i == len - 1)) begin
                errors++;
                $display("FAIL framing ch%0d word%0d: got start=%b end=%b required start=%b end=%b",
                         ch, i, fmt_start_o, fmt_end_o, i == 0, i == len - 1);
            end
            cyc(1);
        end
        checks++;
        if (fmt_req_o !== 1'b0 || fmt_end_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_gap: got req=%b end=%b required 0 0", fmt_req_o, fmt_end_o);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if (fmt_req_o !== 1'b0 || fmt_start_o !== 1'b0 || fmt_end_o !== 1'b0 ||
            fmt_chid_o !== '0 || fmt_length_o !== '0 || fmt_data_o !== '0) begin
            errors++;
            $display("FAIL %s: got req=%b start=%b end=%b chid=%0d len=%0d data=%h required all 0",
                     tag, fmt_req_o, fmt_start_o, fmt_end_o, fmt_chid_o, fmt_length_o, fmt_data_o);
        end
    endtask

    task automatic test_reset();
        cyc(3);
        a2f_val_i = 1'b1;
        a2f_id_i  = 2'd1;
        #1;
        checks++;
        if (f2a_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack: got %b required 0", f2a_ack_o);
        end
        check_zero_outputs("reset_outputs");
        a2f_val_i = 1'b0;
        rstn_i    = 1'b1;
        cyc(1);
    endtask

    task automatic test_full_packet();
        int lat;
        set_code(0, 3'd2);
        for (int i = 0; i < 4; i++) begin
            wr(0, DW'(i), 1'b1);
            if (i < 3) cyc(1);
        end
        wait_req(lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL req_latency: got %0d required 1", lat);
        end
        recv(0, 4, 2);
    endtask

    task automatic test_round_robin();
        set_code(1, 3'd1);
        set_code(2, 3'd1);
        wr(1, 32'h100, 1'b1);
        wr(1, 32'h101, 1'b1);
        // Channel 1 is now in REQ; make both 1 and 2 eligible behind it.
        wr(1, 32'h102, 1'b1);
        wr(1, 32'h103, 1'b1);
        wr(2, 32'h200, 1'b1);
        wr(2, 32'h201, 1'b1);
        recv(1, 2, 0);
        recv(2, 2, 0);
        recv(1, 2, 0);
    endtask

    task automatic test_backpressure();
        set_code(3, 3'd5);
        set_code(0, 3'd2);
        for (int i = 0; i < 32; i++) wr(3, 32'h3000 + DW'(i), 1'b1);
        wr(3, 32'h3FFF, 1'b0);
        wr(0, 32'hA0, 1'b1);
        recv(3, 32, 0);
        a2f_id_i = 2'd3;
        #1;
        checks++;
        if (f2a_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL ack_after_drain: got %b required 1", f2a_ack_o);
        end
        for (int i = 1; i < 4; i++) wr(0, 32'hA0 + DW'(i), 1'b1);
        recv(0, 4, 1);
    endtask

    task automatic test_timeout();
        int lat;
        logic seen;
        set_code(1, 3'd3);
        timeout_i = 16'd10;
        for (int i = 0; i < 3; i++) wr(1, 32'h400 + DW'(i), 1'b1);
        wait_req(lat);
        checks++;
        if (lat != 11) begin
            errors++;
            $display("FAIL timeout_latency: got %0d required 11", lat);
        end
        recv(1, 3, 0);
        timeout_i = 16'd0;
        set_code(2, 3'd3);
        for (int i = 0; i < 3; i++) wr(2, 32'h500 + DW'(i), 1'b1);
        seen = 1'b0;
        repeat (40) begin
            cyc(1);
            if (fmt_req_o !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL timeout_disabled: got req seen=%b required 0", seen);
        end
        timeout_i = 16'd4;
        recv(2, 3, 0);
        timeout_i = 16'd0;
    endtask

    task automatic test_len1_stale();
        int lat;
        set_code(0, 3'd0);
        wr(0, 32'h55, 1'b1);
        recv(0, 1, 0);
        set_code(0, 3'd2);
        for (int i = 0; i < 4; i++) wr(0, 32'h600 + DW'(i), 1'b1);
        wait_req(lat);
        set_code(0, 3'd0);
        recv(0, 4, 1);
        set_code(0, 3'd2);
    endtask

    task automatic test_reset_mid_send();
        int lat;
        logic seen;
        set_code(2, 3'd2);
        for (int i = 0; i < 4; i++) wr(2, 32'h700 + DW'(i), 1'b1);
        wait_req(lat);
        fmt_grant_i = 1'b1;
        cyc(1);
        fmt_grant_i = 1'b0;
        checks++;
        if (fmt_data_o !== 32'h700 || fmt_start_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_first: got data=%h start=%b required 00000700 1", fmt_data_o, fmt_start_o);
        end
        cyc(1);
        checks++;
        if (fmt_data_o !== 32'h701 || fmt_start_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_second: got data=%h start=%b required 00000701 0", fmt_data_o, fmt_start_o);
        end
        rstn_i    = 1'b0;
        a2f_val_i = 1'b1;
        a2f_id_i  = 2'd2;
        cyc(1);
        checks++;
        if (f2a_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ack: got %b required 0", f2a_ack_o);
        end
        check_zero_outputs("mid_reset_outputs");
        a2f_val_i = 1'b0;
        rstn_i    = 1'b1;
        mq[2].delete();
        seen = 1'b0;
        repeat (30) begin
            cyc(1);
            if (fmt_req_o !== 1'b0 || fmt_end_o !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_quiet: got activity=%b required 0", seen);
        end
        for (int i = 0; i < 4; i++) wr(2, 32'h800 + DW'(i), 1'b1);
        recv(2, 4, 0);
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) set_code(c, 3'd2);
        test_reset();
        test_full_packet();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_len1_stale();
        test_reset_mid_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fmt_packer_mc.md
# fmt_packer_mc

Parametrised multi-channel packet formatter between the upstream arbiter (a2f side) and the downstream packet consumer (fmt side). Accepts tagged data words, buffers them in per-channel FIFOs, and emits length-framed packets after a request/grant handshake. Channels are served round-robin. A per-channel idle timeout flushes short packets, so a slow channel never strands data.

## Interface
- DW, 32, data width
- NCH, 4, channel count (2..8)
- CHW, $clog2(NCH), channel id width
- DEPTH, 32, per-channel FIFO depth in words (power of 2, 4..64)
- LW, $clog2(DEPTH)+1, packet length field width
- TOW, 16, timeout counter width

- clk_i  in  1  clock; all logic on rising edge
- rstn_i  in  1  reset, synchronous, active-low
- a2f_val_i  in  1  input word valid
- a2f_id_i  in  CHW  target channel of the input word
- a2f_dat_i  in  DW  input word
- f2a_ack_o  out  1  combinational: FIFO[a2f_id_i] not full and rstn_i high; a word transfers when a2f_val_i & f2a_ack_o
- slv_len_i  in  3*NCH  length code of channel n in bits [3n+2:3n]
- timeout_i  in  TOW  idle cycles before a flush; 0 disables flushing
- fmt_req_o  out  1  packet request
- fmt_chid_o  out  CHW  channel of the requested or current packet
- fmt_length_o  out  LW  word count of the requested or current packet
- fmt_grant_i  in  1  grant from the consumer
- fmt_data_o  out  DW  packet word
- fmt_start_o  out  1  first word of the packet
- fmt_end_o  out  1  last word of the packet

## Operation
- Length decode: code k gives L = 2^k words. Codes with 2^k > DEPTH clamp to DEPTH. Example: code 5 at DEPTH=16 gives L=16.
- Each channel has a FIFO with a count of 0..DEPTH. A write and a read on the same channel in one cycle are legal, and the count is unchanged.
- Timeout counter per channel:
  - Clears on any accepted write to that channel, when the count is 0, or when a packet for that channel enters REQ.
  - Otherwise increments while 0 < count < L, saturating at all-ones.
- A channel is eligible when either condition holds:
  - count ≥ L, which gives a full packet of length L.
  - timeout_i ≠ 0, 0 < count < L, and timer ≥ timeout_i, which gives a short packet of length = count.
- FSM states:
  - IDLE: if any channel is eligible, pick the first eligible channel in round-robin order, starting one after the last served channel (channel 0 first after reset). Latch chid and length, then go to REQ. fmt_grant_i is ignored in IDLE.
  - REQ: fmt_req_o=1, and fmt_chid_o / fmt_length_o hold their latched values. On a sampled fmt_grant_i=1, go to SEND.
  - SEND: pop one word per cycle from the latched channel onto fmt_data_o. fmt_start_o marks the first word and fmt_end_o marks the last (both are set for length 1). After the last word, go to IDLE. fmt_grant_i is ignored in SEND.
- Latched length and chid are not affected by changes to slv_len_i or by new writes after REQ entry.
- Writes continue during REQ and SEND, including writes to the channel being served.

## Timing
- Reset values: fmt_req_o, fmt_start_o, fmt_end_o = 0. fmt_chid_o, fmt_length_o, fmt_data_o = 0. f2a_ack_o = 0 while rstn_i = 0.
- Reset effects: all FIFO counts, timers, and the round-robin pointer clear; FSM goes to IDLE.
- Reset mid-packet: the packet is dropped, outputs return to reset values on the next edge, and no fmt_end_o is produced.
- Write at edge N that makes a channel eligible: fmt_req_o rises after edge N+1.
- Grant sampled high at edge G:
  - fmt_req_o falls after edge G.
  - The first word, with fmt_start_o, is valid after edge G.
  - The remaining words follow on consecutive cycles with no gaps.
- After the fmt_end_o cycle, there is at least one IDLE cycle before the next fmt_req_o.
- Full: f2a_ack_o=0 for that channel only; other channels still accept. A pop in the same cycle does not raise ack combinationally.
- Timeout flush fires with the timer exactly equal to timeout_i: the request rises timeout_i+1 cycles after the last write.

## Test plan
- **Full packet.** Channel 0, code 2; write 0,1,2,3 with a2f_val gaps; grant 2 cycles after req. Expect req after the 4th write; chid=0, length=4; data 0..3, start on 0, end on 3.
- **Round robin.** Channels 1 and 2 both eligible (code 1), then channel 1 eligible again. Expect the order 1, 2, 1, with chid and data matching each channel's writes.
- **Backpressure.** DEPTH=32; write 33 words to channel 3 with no grant. Expect ack=0 on the 33rd word while a channel-0 write is still accepted. After one packet drains, ack=1 again.
- **Timeout flush.** timeout_i=10, code 3; write 3 words. Expect req 11 cycles after the last write with length=3. With timeout_i=0, expect no req.
- **Length-1 packet and stale length.** Code 0 gives one word with start=end=1. In a second case, change slv_len_i during REQ from code 2 to code 0; the packet still sends 4 words.
- **Reset mid-SEND.** Drop rstn_i on the 2nd word of a 4-word packet. Expect outputs 0 on the next edge, FIFOs empty, and no req after reset with no new writes.
